// File: rtl/pm_boot_loader_pkg.sv
`default_nettype none
// ============================================================================
// pm_boot_loader_pkg
// ----------------------------------------------------------------------------
// Shared types and constants for the program-memory boot loader.
//   state_t    : loader FSM state encoding
//   PAD_BYTE   : value written to fill out a partial final instruction word
//   word_mask  : low-address mask selecting the byte lane within a word
// Revision: 1.0 - initial release
// ============================================================================
package pm_boot_loader_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    PAD     = 3'd2,
    RELEASE = 3'd3,
    RUN     = 3'd4,
    ERR     = 3'd5
  } state_t;

  localparam logic [7:0] PAD_BYTE = 8'h00;

  // For a power-of-two word size the in-word byte offset is addr & (n-1).
  function automatic int unsigned word_mask(input int unsigned ins_bytes);
    return ins_bytes - 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pm_boot_loader_if.sv
`default_nettype none
// ============================================================================
// pm_boot_loader_if
// ----------------------------------------------------------------------------
// Byte-stream load channel plus program-memory write port.
//   byte_valid/byte_in/byte_last : byte stream from the image source
//   byte_ready                   : loader accepts a byte this cycle
//   pm_wr_en/pm_addr/pm_wr_data  : program-memory write port
// Modports: master = image source / memory side, slave = loader.
// Revision: 1.0 - initial release
// ============================================================================
interface pm_boot_loader_if #(
  parameter int ADD_WIDTH  = 7,
  parameter int DATA_WIDTH = 8
);
  logic                  byte_valid;
  logic [DATA_WIDTH-1:0] byte_in;
  logic                  byte_last;
  logic                  byte_ready;
  logic                  pm_wr_en;
  logic [ADD_WIDTH-1:0]  pm_addr;
  logic [DATA_WIDTH-1:0] pm_wr_data;

  modport master (
    output byte_valid, byte_in, byte_last,
    input  byte_ready, pm_wr_en, pm_addr, pm_wr_data
  );

  modport slave (
    input  byte_valid, byte_in, byte_last,
    output byte_ready, pm_wr_en, pm_addr, pm_wr_data
  );
endinterface
`default_nettype wire

// File: rtl/pm_boot_loader_write_port.sv
`default_nettype none
// ============================================================================
// pm_write_port_reg
// ----------------------------------------------------------------------------
// Registered program-memory write stage shared by the load and pad paths.
//   clk, rst (async active-low clear)
//   wr_en_d/addr_d/data_d : write request for this cycle
//   wr_en/addr/data       : registered write port toward program memory
// Address/data hold their last value when no write is requested.
// Revision: 1.0 - initial release
// ============================================================================
module pm_write_port_reg #(
  parameter int ADD_WIDTH  = 7,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en_d,
  input  logic [ADD_WIDTH-1:0]  addr_d,
  input  logic [DATA_WIDTH-1:0] data_d,
  output logic                  wr_en,
  output logic [ADD_WIDTH-1:0]  addr,
  output logic [DATA_WIDTH-1:0] data
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_en <= 1'b0;
      addr  <= '0;
      data  <= '0;
    end else begin
      wr_en <= wr_en_d;
      if (wr_en_d) begin
        addr <= addr_d;
        data <= data_d;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/pm_boot_loader.sv
`default_nettype none
// ============================================================================
// pm_boot_loader
// ----------------------------------------------------------------------------
// Boot/load sequencer: streams instruction bytes into program memory, pads the
// final word with zeros to a word boundary, holds the CPU in reset while
// loading and releases it when the image is complete.
//   clk, rst (async active-low)
//   load_req  : start/restart a load (level)
//   bus       : byte stream in + program-memory write port out (slave)
//   cpu_hold  : active-high reset to the CPU core
//   busy      : loading or padding
//   load_done : one-cycle pulse on the first cycle the core runs
//   load_err  : image overflowed the program memory
// Revision: 1.0 - initial release
// ============================================================================
module pm_boot_loader
  import pm_boot_loader_pkg::*;
#(
  parameter int ADD_WIDTH  = 7,
  parameter int DATA_WIDTH = 8,
  parameter int INS_BYTES  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_req,
  pm_boot_loader_if.slave  bus,
  output logic             cpu_hold,
  output logic             busy,
  output logic             load_done,
  output logic             load_err
);

  localparam logic [ADD_WIDTH-1:0] WORD_MASK = ADD_WIDTH'(word_mask(INS_BYTES));

  state_t                state, state_nxt;
  logic [ADD_WIDTH-1:0]  cnt;
  logic                  byte_ready_r;
  logic                  accept;
  logic                  at_word_end;
  logic                  at_top;
  logic                  cnt_clr;
  logic                  wr_en_d;
  logic [DATA_WIDTH-1:0] wr_data_d;

  assign accept      = bus.byte_valid && byte_ready_r;
  // The byte written at cnt completes a word when its lane bits are all ones.
  assign at_word_end = (cnt & WORD_MASK) == WORD_MASK;
  assign at_top      = (cnt == '1);

  always_comb begin
    state_nxt = state;
    wr_en_d   = 1'b0;
    wr_data_d = bus.byte_in;
    cnt_clr   = 1'b0;
    case (state)
      IDLE, RUN, ERR: begin
        if (load_req) begin
          state_nxt = LOAD;
          cnt_clr   = 1'b1;
        end
      end
      LOAD: begin
        if (accept) begin
          wr_en_d = 1'b1;
          if (bus.byte_last)
            state_nxt = at_word_end ? RELEASE : PAD;
          else if (at_top)
            state_nxt = ERR;
        end
      end
      PAD: begin
        wr_en_d   = 1'b1;
        wr_data_d = DATA_WIDTH'(PAD_BYTE);
        if (at_word_end)
          state_nxt = RELEASE;
      end
      RELEASE: state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      cnt          <= '0;
      byte_ready_r <= 1'b0;
      cpu_hold     <= 1'b1;
      load_done    <= 1'b0;
      load_err     <= 1'b0;
    end else begin
      state <= state_nxt;
      // The counter saturates at the top address instead of wrapping.
      if (cnt_clr)
        cnt <= '0;
      else if (wr_en_d && !at_top)
        cnt <= cnt + 1'b1;
      byte_ready_r <= (state_nxt == LOAD);
      cpu_hold     <= (state_nxt != RUN);
      load_done    <= (state == RELEASE);
      // ERR is only left through LOAD, so the flag tracks the ERR state.
      load_err     <= (state_nxt == ERR);
    end
  end

  assign bus.byte_ready = byte_ready_r;
  assign busy           = (state == LOAD) || (state == PAD);

  pm_write_port_reg #(
    .ADD_WIDTH  (ADD_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_write_port (
    .clk     (clk),
    .rst     (rst),
    .wr_en_d (wr_en_d),
    .addr_d  (cnt),
    .data_d  (wr_data_d),
    .wr_en   (bus.pm_wr_en),
    .addr    (bus.pm_addr),
    .data    (bus.pm_wr_data)
  );

endmodule
`default_nettype wire

// File: tb/tb_pm_boot_loader.sv
`default_nettype none
// ============================================================================
// tb_pm_boot_loader
// ----------------------------------------------------------------------------
// Directed self-checking bench for pm_boot_loader: idle after reset, aligned
// and padded images, throttled stream, overflow and recovery, full-memory
// image, reload from RUN and asynchronous reset mid-load.
// Revision: 1.0 - initial release
// ============================================================================
module tb_pm_boot_loader;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic load_req = 1'b0;
  logic cpu_hold, busy, load_done, load_err;

  pm_boot_loader_if #(.ADD_WIDTH(7), .DATA_WIDTH(8)) bif ();

  pm_boot_loader #(.ADD_WIDTH(7), .DATA_WIDTH(8), .INS_BYTES(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .load_req  (load_req),
    .bus       (bif),
    .cpu_hold  (cpu_hold),
    .busy      (busy),
    .load_done (load_done),
    .load_err  (load_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0;

  logic [7:0] img [0:255];
  int         log_addr[$];
  int         log_data[$];
  int         log_cyc[$];
  int         acc_cyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst && bif.pm_wr_en) begin
      log_addr.push_back(int'(bif.pm_addr));
      log_data.push_back(int'(bif.pm_wr_data));
      log_cyc.push_back(cyc);
    end
    if (rst && load_done) done_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    log_addr.delete();
    log_data.delete();
    log_cyc.delete();
    done_cnt = 0;
  endtask

  // Holds load_req across one rising edge; returns on the following negedge.
  task automatic do_load_req();
    @(negedge clk);
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
  endtask

  // Presents img[0..n-1]; records the cycle of each accepted byte.
  task automatic send_bytes(input int n, input bit with_last, input bit rnd,
                            input int max_cyc, output int accepted);
    int idx = 0;
    int cycles = 0;
    acc_cyc.delete();
    while (idx < n && cycles < max_cyc) begin
      @(negedge clk);
      bif.byte_valid = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
      bif.byte_in    = img[idx];
      bif.byte_last  = with_last && (idx == n - 1);
      if (bif.byte_valid && bif.byte_ready) begin
        acc_cyc.push_back(cyc);
        idx++;
      end
      cycles++;
    end
    @(posedge clk);
    #1;
    bif.byte_valid = 1'b0;
    bif.byte_last  = 1'b0;
    accepted = idx;
  endtask

  task automatic wait_release(input int budget, output int fall, output logic done_at);
    fall = -1;
    done_at = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (!cpu_hold) begin
        fall = cyc;
        done_at = load_done;
        break;
      end
    end
  endtask

  // Data bytes land one cycle after acceptance; pad writes follow back to back.
  task automatic check_image(input string tag, input int n_data, input int n_pad);
    int n;
    int exp_cyc;
    check({tag, "_wr_count"}, log_addr.size(), n_data + n_pad);
    n = (log_addr.size() < n_data + n_pad) ? log_addr.size() : n_data + n_pad;
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_addr%0d", tag, i), log_addr[i], i);
      check($sformatf("%s_data%0d", tag, i), log_data[i], (i < n_data) ? int'(img[i]) : 0);
      if (acc_cyc.size() == n_data) begin
        exp_cyc = (i < n_data) ? acc_cyc[i] + 1 : acc_cyc[n_data-1] + 1 + (i - n_data + 1);
        check($sformatf("%s_cyc%0d", tag, i), log_cyc[i], exp_cyc);
      end
    end
  endtask

  task automatic run_image(input string tag, input int n_data, input int n_pad, input bit rnd);
    int acc;
    int fall;
    logic done_at;
    send_bytes(n_data, 1'b1, rnd, 400, acc);
    check({tag, "_accepted"}, acc, n_data);
    wait_release(20, fall, done_at);
    check({tag, "_hold_fall"}, fall, (acc_cyc.size() > 0) ? acc_cyc[acc_cyc.size()-1] + 2 + n_pad : 0);
    check({tag, "_done_at_fall"}, done_at, 1);
    repeat (3) @(negedge clk);
    check({tag, "_done_pulses"}, done_cnt, 1);
    check({tag, "_err"}, load_err, 0);
    check_image(tag, n_data, n_pad);
  endtask

  int bad_hold, bad_ready, bad_wr, acc;
  logic [7:0] boot8 [0:7];

  initial begin
    bif.byte_valid = 1'b0;
    bif.byte_in    = 8'h00;
    bif.byte_last  = 1'b0;
    boot8 = '{8'h13, 8'h05, 8'h50, 8'h00, 8'h93, 8'h05, 8'h10, 8'h00};

    // Asynchronous reset, checked before any clock edge.
    #1 rst = 1'b0;
    #2;
    check("rst_hold", cpu_hold, 1);
    check("rst_ready", bif.byte_ready, 0);
    check("rst_wr_en", bif.pm_wr_en, 0);
    check("rst_busy_done_err", {busy, load_done, load_err}, 3'b000);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // Idle without load_req.
    bad_hold = 0; bad_ready = 0; bad_wr = 0;
    repeat (10) begin
      @(negedge clk);
      if (cpu_hold !== 1'b1) bad_hold++;
      if (bif.byte_ready !== 1'b0) bad_ready++;
      if (bif.pm_wr_en !== 1'b0) bad_wr++;
    end
    check("idle_hold_bad", bad_hold, 0);
    check("idle_ready_bad", bad_ready, 0);
    check("idle_wr_bad", bad_wr, 0);

    // Aligned 8-byte image.
    for (int i = 0; i < 8; i++) img[i] = boot8[i];
    clear_logs();
    do_load_req();
    check("a8_busy", busy, 1);
    check("a8_ready", bif.byte_ready, 1);
    run_image("a8", 8, 0, 1'b0);

    // Reload from RUN, 5-byte image padded to 8.
    img[0] = 8'hB7; img[1] = 8'h42; img[2] = 8'hC3; img[3] = 8'h1D; img[4] = 8'hE9;
    clear_logs();
    do_load_req();
    check("run_reload_hold", cpu_hold, 1);
    check("run_reload_ready", bif.byte_ready, 1);
    run_image("p5", 5, 3, 1'b0);

    // 12-byte image with a throttled byte_valid.
    for (int i = 0; i < 12; i++) img[i] = 8'(8'h30 + 8'(i * 7));
    clear_logs();
    do_load_req();
    run_image("r12", 12, 0, 1'b1);

    // Overflow: 129 bytes without byte_last; only 128 fit.
    for (int i = 0; i < 256; i++) img[i] = 8'(i) ^ 8'hA5;
    clear_logs();
    do_load_req();
    send_bytes(129, 1'b0, 1'b0, 300, acc);
    check("ovf_accepted", acc, 128);
    repeat (2) @(negedge clk);
    check("ovf_err", load_err, 1);
    check("ovf_hold", cpu_hold, 1);
    check("ovf_ready", bif.byte_ready, 0);
    check("ovf_busy", busy, 0);
    check_image("ovf", 128, 0);

    // Recovery from ERR with a full-memory image ending on the top address.
    clear_logs();
    do_load_req();
    check("rec_err_clr", load_err, 0);
    check("rec_ready", bif.byte_ready, 1);
    run_image("full", 128, 0, 1'b0);

    // Asynchronous reset after 3 bytes of a load.
    clear_logs();
    do_load_req();
    send_bytes(3, 1'b0, 1'b0, 20, acc);
    check("mid_accepted", acc, 3);
    check("mid_addr_before", bif.pm_addr, 2);
    #3 rst = 1'b0;
    #1;
    check("mid_rst_wr", {bif.pm_wr_en, bif.pm_addr, bif.pm_wr_data}, 16'h0000);
    check("mid_rst_hold", cpu_hold, 1);
    check("mid_rst_ready", bif.byte_ready, 0);
    check("mid_rst_flags", {busy, load_done, load_err}, 3'b000);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("post_rst_idle", {cpu_hold, bif.byte_ready, busy}, 3'b100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/pm_boot_loader.md
Name: pm_boot_loader

Overview:
- Boot/load sequencer for the pipelined CPU core.
- Accepts a byte-serial instruction stream over a valid/ready handshake and drives the program-memory write port (write enable, address, data) one byte per cycle.
- Pads the final instruction word to a 4-byte boundary.
- Holds the core in reset during loading and releases it once the image is complete; a new load request at any time re-enters loading.

Parameters:
- ADD_WIDTH, 7, program-memory byte address width.
- DATA_WIDTH, 8, byte width of the load stream and program-memory write data.
- INS_BYTES, 4, bytes per instruction word; must be a power of two.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset; one clock domain, asynchronous assertion, active-low.
- load_req  input  1  start (or restart) a load; level, sampled each cycle.
- byte_valid  input  1  byte_in is valid.
- byte_in  input  DATA_WIDTH  instruction byte, little-endian within each word.
- byte_last  input  1  qualifies the final byte of the image.
- byte_ready  output  1  loader accepts a byte this cycle.
- pm_wr_en  output  1  program-memory write enable (registered).
- pm_addr  output  ADD_WIDTH  program-memory write address (registered).
- pm_wr_data  output  DATA_WIDTH  program-memory write data (registered).
- cpu_hold  output  1  active-high reset to the CPU core.
- busy  output  1  state is LOAD or PAD.
- load_done  output  1  one-cycle pulse when the core is released.
- load_err  output  1  sticky overflow flag.

Behaviour:
- Reset (rst=0, async) state and outputs:
  - State IDLE, address counter 0.
  - pm_wr_en=0, pm_addr=0, pm_wr_data=0.
  - cpu_hold=1, byte_ready=0, busy=0, load_done=0, load_err=0.
- Reset asserted mid-load aborts the load immediately; any partial image is left in memory.
- Handshake: a byte is accepted when byte_valid=1 and byte_ready=1. byte_ready is a registered output, high only in LOAD.
- Write latency: an accepted byte appears on pm_wr_en/pm_addr/pm_wr_data on the next cycle, with pm_addr equal to the counter value at acceptance. The counter increments on each write.
- State IDLE:
  - cpu_hold=1.
  - load_req=1 → LOAD; counter cleared; load_err cleared.
- State LOAD:
  - Accept bytes as above.
  - Accepted byte with byte_last=1: if (counter+1) mod INS_BYTES = 0 → RELEASE, else → PAD.
  - Accepted byte with byte_last=0 at counter = 2^ADD_WIDTH-1 → ERR. That byte is still written; the counter does not wrap.
  - byte_last=1 on the final address → RELEASE. This is legal, not an error.
- State PAD:
  - byte_ready=0.
  - Writes 0x00 at successive addresses, one per cycle, until the counter reaches a multiple of INS_BYTES → RELEASE.
  - Maximum INS_BYTES-1 pad writes.
- State RELEASE:
  - Lasts exactly one cycle.
  - cpu_hold deasserts at the end of this cycle (registered).
  - load_done=1 on the cycle cpu_hold first reads 0.
  - → RUN.
- State RUN:
  - cpu_hold=0.
  - load_req=1 → LOAD directly; cpu_hold=1 from the next cycle; counter cleared.
- State ERR:
  - cpu_hold=1, load_err=1, byte_ready=0.
  - Only load_req=1 → LOAD, which clears load_err.
- Simultaneous events:
  - load_req in LOAD or PAD is ignored.
  - load_req=1 in the same cycle as entry to RELEASE is honoured next cycle from RUN.
- Zero-length image (byte_last never seen) stays in LOAD indefinitely with cpu_hold=1.
- pm_wr_en is never high in IDLE, RUN or ERR, except the single write issued for the byte accepted on the transition cycle.

Decomposition:
- Shared package holds:
  - State encoding typedef: IDLE, LOAD, PAD, RELEASE, RUN, ERR.
  - Constant PAD_BYTE = 8'h00.
  - Word-boundary mask derived from INS_BYTES.
- One natural sub-module: pm_write_port_reg, the registered write enable/address/data stage with async active-low clear, shared by the LOAD and PAD paths.
- The FSM and address counter remain in pm_boot_loader.

Test Plan:
- Reset release, no load_req for 10 cycles → cpu_hold=1, byte_ready=0, pm_wr_en=0 throughout.
- load_req, 8 bytes 0x13,0x05,0x50,0x00,0x93,0x05,0x10,0x00 (last on 8th), byte_valid constant:
  - Writes at addr 0..7, one cycle after each accept.
  - No PAD cycles.
  - cpu_hold falls 2 cycles after the last accept; load_done pulses once.
- 5 bytes with byte_last on 5th → data at addr 0..4, then 0x00 at addr 5,6,7, then release.
- byte_valid toggled randomly during a 12-byte load → byte count, addresses and data identical to the back-to-back case; no write on non-accept cycles.
- 129 bytes with no byte_last (ADD_WIDTH=7):
  - Bytes written at addr 0..127; load_err=1; cpu_hold=1.
  - Subsequent load_req clears load_err and restarts at addr 0.
- Interrupt cases:
  - In RUN, load_req → cpu_hold=1 next cycle, reload from addr 0.
  - rst asserted mid-load after 3 bytes → all outputs return to reset values asynchronously.
